// File: rtl/spk_extract_sched.sv
`default_nettype none
// ============================================================================
// Module   : spk_extract_sched
// Purpose  : Schedules spike-waveform extraction from the shared multi-channel
//            history buffer. Peak events (t, ch) are queued (duplicates by
//            channel, overflow and out-of-range channels are dropped). For the
//            head spike the scheduler waits until POST_LEN frames past t have
//            been written, discards it if the oldest sample has already been
//            overwritten, and otherwise issues SPK_LENTH read commands for
//            frames t-PRE_LEN .. t+POST_LEN over a valid/ready handshake.
// Ports    : clk, rst (sync, active high)
//            frame_No_in            frame currently being written
//            peak_valid_in/t/ch     peak event strobe and payload
//            rd_valid/rd_ready      read command handshake
//            rd_ch/rd_frame/rd_idx/rd_last  read command payload
//            spk_done_pulse         1 cycle after the last command handshake
//            busy, pend_cnt         activity / queue occupancy
//            drop_*_cnt             saturating drop counters
// Revision : 1.0 - initial release
// ============================================================================
module spk_extract_sched #(
    parameter int NUM_CH     = 160,
    parameter int WIDTH_CH   = 12,
    parameter int PRE_LEN    = 9,
    parameter int POST_LEN   = 9,
    parameter int HIST_DEPTH = 32,
    parameter int PEND_DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         frame_No_in,
    input  logic                peak_valid_in,
    input  logic [31:0]         peak_t_in,
    input  logic [WIDTH_CH-1:0] peak_ch_in,
    output logic                rd_valid,
    input  logic                rd_ready,
    output logic [WIDTH_CH-1:0] rd_ch,
    output logic [31:0]         rd_frame,
    output logic [15:0]         rd_idx,
    output logic                rd_last,
    output logic                spk_done_pulse,
    output logic                busy,
    output logic [2:0]          pend_cnt,
    output logic [15:0]         drop_full_cnt,
    output logic [15:0]         drop_dup_cnt,
    output logic [15:0]         drop_stale_cnt
);

    localparam int SPK_LENTH = PRE_LEN + 1 + POST_LEN;
    localparam int PTR_W     = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;

    localparam logic [31:0] c_num_ch    = NUM_CH;
    localparam logic [31:0] c_pre_len   = PRE_LEN;
    // Oldest sample t-PRE_LEN must still be inside the retained window.
    localparam logic [31:0] c_stale_age = HIST_DEPTH - 1 - PRE_LEN;
    // Frame t+POST_LEN is complete once the writer has moved past it.
    localparam logic [31:0] c_ready_age = POST_LEN + 1;
    localparam logic [15:0] c_last_idx  = 16'(SPK_LENTH - 1);
    localparam logic [2:0]  c_depth     = 3'(PEND_DEPTH);
    localparam logic [15:0] c_sat       = 16'hFFFF;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_ISSUE = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;

    logic [31:0]         r_q_t  [PEND_DEPTH];
    logic [WIDTH_CH-1:0] r_q_ch [PEND_DEPTH];
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [2:0]          r_cnt;

    logic                r_rd_valid;
    logic [WIDTH_CH-1:0] r_rd_ch;
    logic [31:0]         r_rd_frame;
    logic [15:0]         r_rd_idx;
    logic                r_rd_last;
    logic                r_done;
    logic [15:0]         r_drop_full;
    logic [15:0]         r_drop_dup;
    logic [15:0]         r_drop_stale;

    logic [PEND_DEPTH-1:0] w_match;
    logic [31:0]         w_ch_ext;
    logic                w_ch_ok;
    logic                w_dup;
    logic                w_full;
    logic                w_push;
    logic                w_pop;
    logic                w_hs;
    logic                w_last_hs;
    logic [31:0]         w_age;
    logic                w_stale;
    logic                w_go;
    logic [2:0]          w_cnt_after_pop;

    // Duplicate detection against every occupied slot, head included.
    for (genvar gi = 0; gi < PEND_DEPTH; gi++) begin : g_dup
        logic [PTR_W-1:0] w_off;
        assign w_off        = PTR_W'(gi) - r_rd_ptr;
        assign w_match[gi]  = (3'(w_off) < r_cnt) && (r_q_ch[gi] == peak_ch_in);
    end

    assign w_ch_ext        = {{(32 - WIDTH_CH){1'b0}}, peak_ch_in};
    assign w_ch_ok         = (w_ch_ext < c_num_ch);
    assign w_dup           = |w_match;
    assign w_hs            = r_rd_valid && rd_ready;
    assign w_last_hs       = (r_state == S_ISSUE) && w_hs && r_rd_last;

    // Modular subtraction keeps the age correct across frame-counter wrap.
    assign w_age           = frame_No_in - r_q_t[r_rd_ptr];
    assign w_stale         = (w_age > c_stale_age);
    assign w_go            = !w_stale && (w_age >= c_ready_age);

    assign w_pop           = ((r_state == S_WAIT) && w_stale) || w_last_hs;
    assign w_cnt_after_pop = r_cnt - 3'(w_pop);
    assign w_full          = (w_cnt_after_pop == c_depth);
    assign w_push          = peak_valid_in && w_ch_ok && !w_dup && !w_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_cnt != 3'd0) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (w_stale) begin
                    w_state_nxt = S_IDLE;
                end else if (w_go) begin
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (w_last_hs) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PEND_DEPTH; i++) begin
                r_q_t[i]  <= '0;
                r_q_ch[i] <= '0;
            end
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_cnt        <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_ch      <= '0;
            r_rd_frame   <= '0;
            r_rd_idx     <= '0;
            r_rd_last    <= 1'b0;
            r_done       <= 1'b0;
            r_drop_full  <= '0;
            r_drop_dup   <= '0;
            r_drop_stale <= '0;
        end else begin
            if (w_push) begin
                r_q_t[r_wr_ptr]  <= peak_t_in;
                r_q_ch[r_wr_ptr] <= peak_ch_in;
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_cnt <= w_cnt_after_pop + 3'(w_push);

            if (peak_valid_in && w_ch_ok && w_dup && (r_drop_dup != c_sat)) begin
                r_drop_dup <= r_drop_dup + 16'd1;
            end
            if (peak_valid_in && w_ch_ok && !w_dup && w_full && (r_drop_full != c_sat)) begin
                r_drop_full <= r_drop_full + 16'd1;
            end
            if ((r_state == S_WAIT) && w_stale && (r_drop_stale != c_sat)) begin
                r_drop_stale <= r_drop_stale + 16'd1;
            end

            r_done <= w_last_hs;

            if ((r_state == S_WAIT) && w_go) begin
                r_rd_valid <= 1'b1;
                r_rd_ch    <= r_q_ch[r_rd_ptr];
                r_rd_frame <= r_q_t[r_rd_ptr] - c_pre_len;
                r_rd_idx   <= '0;
                r_rd_last  <= (c_last_idx == 16'd0);
            end else if ((r_state == S_ISSUE) && w_hs) begin
                if (r_rd_last) begin
                    r_rd_valid <= 1'b0;
                    r_rd_ch    <= '0;
                    r_rd_frame <= '0;
                    r_rd_idx   <= '0;
                    r_rd_last  <= 1'b0;
                end else begin
                    r_rd_frame <= r_rd_frame + 32'd1;
                    r_rd_idx   <= r_rd_idx + 16'd1;
                    r_rd_last  <= ((r_rd_idx + 16'd1) == c_last_idx);
                end
            end
        end
    end

    assign rd_valid       = r_rd_valid;
    assign rd_ch          = r_rd_ch;
    assign rd_frame       = r_rd_frame;
    assign rd_idx         = r_rd_idx;
    assign rd_last        = r_rd_last;
    assign spk_done_pulse = r_done;
    assign busy           = (r_state != S_IDLE) || (r_cnt != 3'd0);
    assign pend_cnt       = r_cnt;
    assign drop_full_cnt  = r_drop_full;
    assign drop_dup_cnt   = r_drop_dup;
    assign drop_stale_cnt = r_drop_stale;

endmodule
`default_nettype wire

// File: tb/tb_spk_extract_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_spk_extract_sched
// Purpose  : Directed self-checking bench for spk_extract_sched. A negedge
//            monitor checks every read command against the expected frame
//            sequence, handshake stability and done-pulse timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spk_extract_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] frame_No_in;
    logic        peak_valid_in;
    logic [31:0] peak_t_in;
    logic [11:0] peak_ch_in;
    logic        rd_valid;
    logic        rd_ready;
    logic [11:0] rd_ch;
    logic [31:0] rd_frame;
    logic [15:0] rd_idx;
    logic        rd_last;
    logic        spk_done_pulse;
    logic        busy;
    logic [2:0]  pend_cnt;
    logic [15:0] drop_full_cnt;
    logic [15:0] drop_dup_cnt;
    logic [15:0] drop_stale_cnt;

    always #5 clk = ~clk;

    spk_extract_sched dut (
        .clk            (clk),
        .rst            (rst),
        .frame_No_in    (frame_No_in),
        .peak_valid_in  (peak_valid_in),
        .peak_t_in      (peak_t_in),
        .peak_ch_in     (peak_ch_in),
        .rd_valid       (rd_valid),
        .rd_ready       (rd_ready),
        .rd_ch          (rd_ch),
        .rd_frame       (rd_frame),
        .rd_idx         (rd_idx),
        .rd_last        (rd_last),
        .spk_done_pulse (spk_done_pulse),
        .busy           (busy),
        .pend_cnt       (pend_cnt),
        .drop_full_cnt  (drop_full_cnt),
        .drop_dup_cnt   (drop_dup_cnt),
        .drop_stale_cnt (drop_stale_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Monitor state; expectations are written only by the stimulus block.
    logic        mon_clr = 1'b0;
    logic [31:0] exp_base = '0;
    logic [11:0] exp_ch = '0;
    int          hs_cnt;
    int          done_cnt;
    logic [31:0] first_frame;
    logic        prev_valid, prev_stall, prev_last_hs;
    logic [11:0] sv_ch;
    logic [31:0] sv_frame;
    logic [15:0] sv_idx;
    logic        sv_last;

    always @(negedge clk) begin
        if (mon_clr) begin
            hs_cnt = 0; done_cnt = 0; first_frame = '0;
            prev_valid = 0; prev_stall = 0; prev_last_hs = 0;
        end else if (rst) begin
            prev_valid = 0; prev_stall = 0; prev_last_hs = 0;
        end else begin
            if (prev_stall) begin
                check("hold_valid", {31'd0, rd_valid}, 32'd1);
                check("hold_ch", {20'd0, rd_ch}, {20'd0, sv_ch});
                check("hold_frame", rd_frame, sv_frame);
                check("hold_idx", {16'd0, rd_idx}, {16'd0, sv_idx});
                check("hold_last", {31'd0, rd_last}, {31'd0, sv_last});
            end
            if (prev_last_hs) check("done_after_last", {31'd0, spk_done_pulse}, 32'd1);
            else if (spk_done_pulse) check("done_spurious", {31'd0, spk_done_pulse}, 32'd0);
            if (spk_done_pulse) done_cnt++;
            if (rd_valid && !prev_valid) first_frame = frame_No_in;
            prev_last_hs = 0;
            if (rd_valid && rd_ready) begin
                check("cmd_frame", rd_frame, exp_base + 32'(hs_cnt));
                check("cmd_idx", {16'd0, rd_idx}, 32'(hs_cnt));
                check("cmd_ch", {20'd0, rd_ch}, {20'd0, exp_ch});
                check("cmd_last", {31'd0, rd_last}, {31'd0, (hs_cnt == 18)});
                prev_last_hs = rd_last;
                hs_cnt++;
            end
            prev_stall = rd_valid && !rd_ready;
            prev_valid = rd_valid;
            sv_ch = rd_ch; sv_frame = rd_frame; sv_idx = rd_idx; sv_last = rd_last;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1;
        mon_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; peak_valid_in = 1'b0; rd_ready = 1'b1;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [31:0] t, input logic [11:0] ch);
        peak_valid_in = 1'b1; peak_t_in = t; peak_ch_in = ch;
        tick();
        peak_valid_in = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, {31'd0, rd_valid}, 32'd0);
        check({tag, "_ch"}, {20'd0, rd_ch}, 32'd0);
        check({tag, "_frame"}, rd_frame, 32'd0);
        check({tag, "_idx"}, {16'd0, rd_idx}, 32'd0);
        check({tag, "_last"}, {31'd0, rd_last}, 32'd0);
        check({tag, "_done"}, {31'd0, spk_done_pulse}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_pend"}, {29'd0, pend_cnt}, 32'd0);
        check({tag, "_full"}, {16'd0, drop_full_cnt}, 32'd0);
        check({tag, "_dup"}, {16'd0, drop_dup_cnt}, 32'd0);
        check({tag, "_stale"}, {16'd0, drop_stale_cnt}, 32'd0);
    endtask

    // Runs until the scheduler goes idle, optionally ramping the frame
    // counter every 16 cycles and randomising rd_ready.
    task automatic run(input string tag, input int max_cyc, input bit ramp, input bit rnd);
        bit finished = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (rnd) rd_ready = 1'($urandom_range(0, 1));
            tick();
            if (ramp && ((i % 16) == 15)) frame_No_in = frame_No_in + 32'd1;
            if (!busy) begin
                finished = 1'b1;
                break;
            end
        end
        check({tag, "_idle_in_time"}, {31'd0, finished}, 32'd1);
        rd_ready = 1'b1;
        tick(); tick();
    endtask

    initial begin
        bit found;
        frame_No_in = '0; peak_t_in = '0; peak_ch_in = '0;
        do_reset();
        clear_mon();
        check_zero("reset");

        // 1: basic extraction with slow frame ramp
        frame_No_in = 32'd100;
        exp_base = 32'd91; exp_ch = 12'd5;
        push(32'd100, 12'd5);
        check("t1_pend", {29'd0, pend_cnt}, 32'd1);
        run("t1", 400, 1'b1, 1'b0);
        check("t1_start_frame", first_frame, 32'd110);
        check("t1_hs", 32'(hs_cnt), 32'd19);
        check("t1_done", 32'(done_cnt), 32'd1);

        // 2: duplicate channel while pending
        do_reset(); clear_mon();
        frame_No_in = 32'd200;
        exp_base = 32'd191; exp_ch = 12'd7;
        push(32'd200, 12'd7);
        push(32'd202, 12'd7);
        frame_No_in = 32'd210;
        run("t2", 100, 1'b0, 1'b0);
        check("t2_dup", {16'd0, drop_dup_cnt}, 32'd1);
        check("t2_full", {16'd0, drop_full_cnt}, 32'd0);
        check("t2_hs", 32'(hs_cnt), 32'd19);
        check("t2_done", 32'(done_cnt), 32'd1);

        // 3: out-of-range channel, then overflow
        do_reset(); clear_mon();
        frame_No_in = 32'd1000;
        push(32'd1000, 12'd160);
        tick();
        check("t3_range_pend", {29'd0, pend_cnt}, 32'd0);
        check("t3_range_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 5; i++) push(32'd1000, 12'(10 + i));
        check("t3_pend", {29'd0, pend_cnt}, 32'd4);
        check("t3_full", {16'd0, drop_full_cnt}, 32'd1);
        check("t3_dup", {16'd0, drop_dup_cnt}, 32'd0);

        // 4: stale drop, plus the age boundary on both sides
        do_reset(); clear_mon();
        frame_No_in = 32'd50;
        push(32'd50, 12'd9);
        tick(); tick(); tick();
        frame_No_in = 32'd80;
        run("t4", 50, 1'b0, 1'b0);
        check("t4_stale", {16'd0, drop_stale_cnt}, 32'd1);
        check("t4_hs", 32'(hs_cnt), 32'd0);
        check("t4_pend", {29'd0, pend_cnt}, 32'd0);
        clear_mon();
        frame_No_in = 32'd300;
        exp_base = 32'd291; exp_ch = 12'd4;
        push(32'd300, 12'd4);
        frame_No_in = 32'd322;
        run("t4b", 100, 1'b0, 1'b0);
        check("t4b_stale", {16'd0, drop_stale_cnt}, 32'd1);
        check("t4b_hs", 32'(hs_cnt), 32'd19);
        clear_mon();
        frame_No_in = 32'd400;
        push(32'd400, 12'd6);
        frame_No_in = 32'd423;
        run("t4c", 50, 1'b0, 1'b0);
        check("t4c_stale", {16'd0, drop_stale_cnt}, 32'd2);
        check("t4c_hs", 32'(hs_cnt), 32'd0);

        // 5: random backpressure
        do_reset(); clear_mon();
        frame_No_in = 32'd500;
        exp_base = 32'd491; exp_ch = 12'd20;
        push(32'd500, 12'd20);
        frame_No_in = 32'd510;
        run("t5", 400, 1'b0, 1'b1);
        check("t5_hs", 32'(hs_cnt), 32'd19);
        check("t5_done", 32'(done_cnt), 32'd1);

        // 6a: frame counter wrap, full extraction
        do_reset(); clear_mon();
        frame_No_in = 32'hFFFF_FFFE;
        exp_base = 32'hFFFF_FFF5; exp_ch = 12'd3;
        push(32'hFFFF_FFFE, 12'd3);
        frame_No_in = 32'd8;
        run("t6a", 100, 1'b0, 1'b0);
        check("t6a_hs", 32'(hs_cnt), 32'd19);
        check("t6a_done", 32'(done_cnt), 32'd1);

        // 6b: reset in the middle of ISSUE
        clear_mon();
        frame_No_in = 32'hFFFF_FFFE;
        push(32'hFFFF_FFFE, 12'd3);
        frame_No_in = 32'd8;
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rd_valid && (rd_idx == 16'd5)) begin
                found = 1'b1;
                break;
            end
        end
        check("t6b_reached_idx5", {31'd0, found}, 32'd1);
        check("t6b_frame_idx5", rd_frame, 32'hFFFF_FFFA);
        rst = 1'b1;
        tick();
        check_zero("t6b_rst");
        rst = 1'b0;
        tick(); tick();
        check("t6b_hs", 32'(hs_cnt), 32'd5);
        check("t6b_no_done", 32'(done_cnt), 32'd0);
        check("t6b_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
